operand_entry: RTL

//  - Input-side counterpart of the display path: turns raw switches plus two pushbuttons into a clean,

---
 rtl/operand_entry_pkg.sv | 14 +
 rtl/operand_entry_button_debouncer.sv | 46 ++++
 rtl/operand_entry.sv | 108 ++++++++++
 3 files changed

// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand entry path: entry-state encoding and default sizing.
package operand_entry_pkg;

  localparam int unsigned ENTRY_STATE_W       = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 5000;
  localparam int unsigned OP_W_DEF            = 4;

  typedef enum logic [ENTRY_STATE_W-1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_DONE = 2'b10
  } entry_state_e;

endpackage

// File: rtl/operand_entry_button_debouncer.sv
// One pushbutton: 2-FF synchroniser, stability counter, debounced level and a one-cycle press pulse.
module button_debouncer
  import operand_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Level flips only after the synchronised input has disagreed with it for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= ~level;
          cnt   <= '0;
          press <= ~level;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Operand entry sequencer: debounced ENTER/CLEAR drive an A -> B -> DONE FSM latching switch operands.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned OP_W            = OP_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [OP_W-1:0]          sw,
  input  logic                     btn_enter,
  input  logic                     btn_clear,
  output logic [OP_W-1:0]          op_a,
  output logic [OP_W-1:0]          op_b,
  output logic                     operands_valid,
  output logic                     load,
  output logic [ENTRY_STATE_W-1:0] entry_state
);

  logic enter_p;
  logic clear_p;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_enter),
    .press (enter_p)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_clear),
    .press (clear_p)
  );

  entry_state_e    state;
  entry_state_e    state_nxt;
  logic [OP_W-1:0] op_a_nxt;
  logic [OP_W-1:0] op_b_nxt;
  logic            valid_nxt;
  logic            load_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_A;
      op_a           <= '0;
      op_b           <= '0;
      operands_valid <= 1'b0;
      load           <= 1'b0;
    end else begin
      state          <= state_nxt;
      op_a           <= op_a_nxt;
      op_b           <= op_b_nxt;
      operands_valid <= valid_nxt;
      load           <= load_nxt;
    end
  end

  // Clear takes priority over a coincident enter; the unused encoding falls back to a cleared S_A.
  always_comb begin
    state_nxt = state;
    op_a_nxt  = op_a;
    op_b_nxt  = op_b;
    valid_nxt = operands_valid;
    load_nxt  = 1'b0;
    if (clear_p) begin
      state_nxt = S_A;
      op_a_nxt  = '0;
      op_b_nxt  = '0;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        S_A: begin
          if (enter_p) begin
            op_a_nxt  = sw;
            state_nxt = S_B;
          end
        end
        S_B: begin
          if (enter_p) begin
            op_b_nxt  = sw;
            valid_nxt = 1'b1;
            load_nxt  = 1'b1;
            state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (enter_p) begin
            op_a_nxt  = sw;
            op_b_nxt  = '0;
            valid_nxt = 1'b0;
            state_nxt = S_B;
          end
        end
        default: begin
          state_nxt = S_A;
          op_a_nxt  = '0;
          op_b_nxt  = '0;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  assign entry_state = state;

endmodule
